// File: rtl/data_pipe_pkg.sv
// Shared definitions for the narrow/wide data pipe packer and unpacker.
// Counter width helper sized for lane indices 0..n-1.
package data_pipe_pkg;

  function automatic int pipe_cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/data_pipe_oreg.sv
// One-entry valid/ready output register.
// Holds its payload stable while downstream stalls.
module data_pipe_oreg #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         ready_i,
  output logic         vld_o,
  output logic [W-1:0] data_o,
  output logic         free_o
);

  logic         vld_q, vld_d;
  logic [W-1:0] data_q, data_d;

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    if (load_i) begin
      vld_d  = 1'b1;
      data_d = data_i;
    end else if (vld_q && ready_i) begin
      vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end
  end

  assign vld_o  = vld_q;
  assign data_o = data_q;
  assign free_o = !vld_q || ready_i;

endmodule

// File: rtl/data_pipe_1ton.sv
// Narrow-to-wide packer: first accepted word lands in the MS lane.
// wr_last flushes a partial group with a lane-valid mask.
module data_pipe_1ton
  import data_pipe_pkg::*;
#(
  parameter int DSIZE = 1,
  parameter int NSIZE = 8
) (
  input  logic                   clock,
  input  logic                   rst_n,
  input  logic [DSIZE-1:0]       wr_data,
  input  logic                   wr_vld,
  input  logic                   wr_last,
  output logic                   wr_ready,
  output logic [DSIZE*NSIZE-1:0] rd_data,
  output logic [NSIZE-1:0]       rd_keep,
  output logic                   rd_last,
  output logic                   rd_vld,
  input  logic                   rd_ready
);

  localparam int CNT_W = pipe_cnt_w(NSIZE);
  localparam int WW    = DSIZE * NSIZE;
  localparam int PW    = WW + NSIZE + 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WW-1:0]    asm_q, asm_d;
  logic [WW-1:0]    merged;
  logic [NSIZE-1:0] keep;
  logic [CNT_W-1:0] lane;
  logic             free;
  logic             wr_fire;
  logic             close;
  logic [PW-1:0]    pay_o;

  assign wr_ready = rst_n && free;
  assign wr_fire  = wr_vld && wr_ready;
  assign close    = wr_fire &&
                    (wr_last || cnt_q == CNT_W'(NSIZE - 1));
  assign lane     = CNT_W'(NSIZE - 1) - cnt_q;

  always_comb begin
    merged = asm_q;
    keep   = '0;
    for (int k = 0; k < NSIZE; k++) begin
      if (k == int'(lane)) merged[DSIZE*k +: DSIZE] = wr_data;
      if (k >= int'(lane)) keep[k] = 1'b1;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    asm_d = asm_q;
    if (close) begin
      cnt_d = '0;
      asm_d = '0;
    end else if (wr_fire) begin
      cnt_d = cnt_q + CNT_W'(1);
      asm_d = merged;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      asm_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      asm_q <= asm_d;
    end
  end

  data_pipe_oreg #(.W(PW)) u_oreg (
    .clock   (clock),
    .rst_n   (rst_n),
    .load_i  (close),
    .data_i  ({merged, keep, wr_last}),
    .ready_i (rd_ready),
    .vld_o   (rd_vld),
    .data_o  (pay_o),
    .free_o  (free)
  );

  assign rd_data = pay_o[PW-1 -: WW];
  assign rd_keep = pay_o[NSIZE:1];
  assign rd_last = pay_o[0];

endmodule
